// File: rtl/pwm_duty_feeder_pkg.sv
// Shared modulator DSP definitions: duty format, PWM period and the
// sample-to-duty conversion reused by other modulator blocks.
package pwm_duty_feeder_pkg;

    localparam int                DUTY_W     = 8;
    localparam logic [DUTY_W-1:0] DUTY_MID   = 8'h80;
    localparam int                PWM_PERIOD = 256;

    // topBits is the signed top byte followed by the round bit.
    // The result is rounded, saturated at +127 and then converted to offset binary.
    function automatic logic [DUTY_W-1:0] dutyConvert(input logic [DUTY_W:0] topBits);
        logic [DUTY_W:0] sum;
        sum = {topBits[DUTY_W], topBits[DUTY_W:1]} + {{DUTY_W{1'b0}}, topBits[0]};
        if (!sum[DUTY_W] && sum[DUTY_W-1]) begin
            sum = {2'b00, {(DUTY_W-1){1'b1}}};
        end
        return sum[DUTY_W-1:0] ^ DUTY_MID;
    endfunction

endpackage

// File: rtl/pwm_duty_feeder_if.sv
// Valid/ready sample handshake between the audio source (master) and the
// duty feeder (slave).
interface pwm_duty_feeder_if #(
    parameter int SAMPLE_W = 16
);
    logic signed [SAMPLE_W-1:0] ipSample;
    logic                       ipValid;
    logic                       opReady;

    modport master (output ipSample, output ipValid, input opReady);
    modport slave  (input ipSample, input ipValid, output opReady);
endinterface

// File: rtl/pwm_duty_feeder_sync_fifo.sv
// Single-clock FIFO with full/empty flags and a look-ahead full flag, so the
// owner can register its ready output from the post-update occupancy.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             ipClk,
    input  logic             nReset,
    input  logic             wrEn,
    input  logic [WIDTH-1:0] wrData,
    input  logic             rdEn,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty,
    output logic             fullNext
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;
    logic [AW:0]      countNext;
    logic             doWr;
    logic             doRd;

    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    assign doWr     = wrEn && !full;
    assign doRd     = rdEn && !empty;
    assign rdData   = mem[rdPtr];
    assign fullNext = (countNext == DEPTH_CNT);

    always_comb begin
        // NOTE: default first so every path assigns countNext and no latch is inferred.
        countNext = count;
        if (doWr && !doRd) begin
            countNext = count + 1'b1;
        end else if (doRd && !doWr) begin
            countNext = count - 1'b1;
        end
    end

    always_ff @(posedge ipClk or negedge nReset) begin
        if (!nReset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values whatever the statement order.
            count <= countNext;
            if (doWr) wrPtr <= wrPtr + 1'b1;
            if (doRd) rdPtr <= rdPtr + 1'b1;
        end
    end

    // NOTE: storage has no reset; clearing the occupancy makes stale entries unreachable.
    always_ff @(posedge ipClk) begin
        if (doWr) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/pwm_duty_feeder.sv
// Buffers signed audio samples and hands the PWM one offset-binary duty value
// per period, changing it only at the period boundary.
module pwm_duty_feeder
    import pwm_duty_feeder_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int DEPTH    = 4,
    parameter int PERIOD   = PWM_PERIOD
) (
    input  logic              ipClk,
    input  logic              ipReset,
    pwm_duty_feeder_if.slave  sampleBus,
    output logic [DUTY_W-1:0] opDutyCycle,
    output logic              opUpdate,
    output logic              opSync,
    output logic              opUnderrun,
    output logic [7:0]        opUnderrunCount
);
    localparam int               CNT_W    = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] periodCnt;
    logic             periodRun;
    logic             boundary;
    logic             push;
    logic             pop;
    logic             readyReg;
    logic [DUTY_W:0]  fifoHead;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             fifoFullNext;

    assign sampleBus.opReady = readyReg;
    assign boundary = periodRun && (periodCnt == LAST_CNT);
    assign push     = sampleBus.ipValid && readyReg && !fifoFull;
    assign pop      = boundary && !fifoEmpty;

    // Only the top byte and round bit are needed, so only those are buffered.
    sync_fifo #(
        .WIDTH (DUTY_W + 1),
        .DEPTH (DEPTH)
    ) sampleFifo (
        .ipClk    (ipClk),
        .nReset   (ipReset),
        .wrEn     (push),
        .wrData   (sampleBus.ipSample[SAMPLE_W-1 -: DUTY_W+1]),
        .rdEn     (pop),
        .rdData   (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .fullNext (fifoFullNext)
    );

    // The first edge after reset release is cycle 0 of the first period.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            periodRun <= 1'b0;
            periodCnt <= '0;
            opSync    <= 1'b0;
        end else begin
            periodRun <= 1'b1;
            opSync    <= !periodRun || (periodCnt == LAST_CNT);
            if (periodRun) begin
                periodCnt <= (periodCnt == LAST_CNT) ? '0 : periodCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            readyReg        <= 1'b0;
            opDutyCycle     <= DUTY_MID;
            opUpdate        <= 1'b0;
            opUnderrun      <= 1'b0;
            opUnderrunCount <= '0;
        end else begin
            readyReg   <= !fifoFullNext;
            opUpdate   <= pop;
            opUnderrun <= boundary && fifoEmpty;
            if (pop) begin
                opDutyCycle <= dutyConvert(fifoHead);
            end
            if (boundary && fifoEmpty && (opUnderrunCount != 8'hFF)) begin
                opUnderrunCount <= opUnderrunCount + 1'b1;
            end
        end
    end

endmodule

// File: doc/pwm_duty_feeder.md
Name: pwm_duty_feeder

Overview:
- Upstream stage of the modulator PWM. Accepts signed audio samples over a valid/ready handshake and buffers them in a small FIFO.
- Converts each sample to an 8-bit offset-binary duty cycle with rounding and saturation.
- Presents one new duty value per PWM period, updated only at the period boundary, so the downstream PWM never sees a mid-period change.
- Reports underruns when no sample is available at a boundary.

Parameters:
- SAMPLE_W, 16, signed input sample width (must be >= 9).
- DEPTH, 4, FIFO depth in samples (power of 2, >= 2).
- PERIOD, 256, clocks per PWM period (must equal the downstream PWM counter span).

Ports:
- ipClk  input  1  system clock; all logic on the rising edge.
- ipReset  input  1  asynchronous, active-low reset (low = in reset).
- ipSample  input  SAMPLE_W  signed two's-complement sample.
- ipValid  input  1  ipSample is valid this cycle.
- opReady  output  1  block can accept a sample this cycle.
- opDutyCycle  output  8  duty value to the PWM; held constant for a whole period.
- opUpdate  output  1  one-cycle pulse, asserted the cycle opDutyCycle takes a new popped value.
- opSync  output  1  one-cycle pulse on the first cycle of each period (period counter == 0); used to align the PWM counter.
- opUnderrun  output  1  one-cycle pulse, asserted when a boundary finds the FIFO empty.
- opUnderrunCount  output  8  saturating count of underruns since reset.

Behaviour:
- Reset values (asynchronous assert): opDutyCycle = 0x80 (midscale, silence); opUpdate, opSync, opUnderrun = 0; opUnderrunCount = 0; FIFO empty; period counter = 0; opReady = 0.
- Reset release: first clock edge after release sets opReady = 1 (FIFO empty). Reset asserted mid-operation discards all buffered samples immediately.
- Period counter:
  - Counts 0..PERIOD-1, then wraps to 0.
  - Free-running out of reset.
  - opSync = 1 while the counter is 0, including the first period after reset.
- Handshake:
  - Write occurs when ipValid && opReady.
  - opReady is registered: opReady = !full, based on occupancy after the current cycle's push and pop.
  - ipValid while opReady = 0 is ignored; the sample is not stored and is not an error.
- Boundary event: when the counter == PERIOD-1.
  - FIFO non-empty: pop head; on the next edge opDutyCycle = conv(head) and opUpdate = 1 for that cycle, which coincides with counter == 0.
  - FIFO empty: opDutyCycle holds its previous value; opUnderrun = 1 in the cycle counter == 0; opUnderrunCount increments and saturates at 0xFF.
- Simultaneous events:
  - Push and pop in the same cycle: occupancy unchanged.
  - Push into an empty FIFO on a boundary cycle: the pop sees empty and underruns; the sample is stored and used at the next boundary.
  - Pop on a full FIFO frees a slot; opReady rises the next cycle.
- Latency: a sample at the FIFO head reaches opDutyCycle one clock after the next boundary. The minimum is 1 clock, when it was written before the boundary cycle.
- Conversion conv(s):
  - t = s[SAMPLE_W-1 -: 8] (signed top byte); r = s[SAMPLE_W-9] (round bit).
  - v = t + r in 9-bit signed.
  - If v > 127, then v = 127; no negative overflow is possible.
  - duty = v[7:0] ^ 0x80.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared DSP package:
  - DUTY_W = 8.
  - DUTY_MID = 8'h80.
  - PWM_PERIOD = 256.
  - The conversion function (offset-binary round and saturate), so other modulator blocks reuse it.
- Sub-module: sync_fifo, a parameterised width/depth FIFO with full/empty flags. It uses the same async active-low reset.

Test Plan:
- Reset, then idle for 600 clocks with ipValid = 0:
  - opDutyCycle stays 0x80.
  - opSync pulses at cycles 0, 256, 512.
  - opUnderrun pulses at each boundary; opUnderrunCount = 2 after the second boundary.
- Conversion sweep, one sample per period: 0x0000, 0x7FFF, 0x8000, 0x0180, 0xFF7F, 0xFF80, 0x7F80 -> opDutyCycle sequence 0x80, 0xFF, 0x00, 0x82, 0x7F, 0x80, 0xFF (saturated), each with an opUpdate pulse coinciding with opSync.
- Burst of 6 samples on consecutive cycles, ipValid held high, DEPTH = 4:
  - First 4 accepted; opReady falls after the 4th.
  - Samples 5 and 6 are dropped until a pop.
  - After the next boundary, opReady = 1 one cycle later.
- Write a sample exactly on the cycle counter == PERIOD-1 with an empty FIFO -> opUnderrun at that boundary, then the value appears at the following boundary.
- Assert ipReset low mid-period with 3 samples buffered -> outputs return to reset values immediately; after release no stale sample is ever output and opUnderrunCount = 0.
- Starve for 300 periods -> opUnderrunCount saturates at 0xFF and does not wrap.
